vga_framebuffer: RTL and testbench

Memory-mapped 12-bit colour framebuffer and 640x480@60 Hz VGA scan-out engine sitting directly downstream of the CPU's store path. The CPU writes pixels through a valid/ready port, and the block drives the board's `hsync`, `vsync`, `red`, `green` and `blue` pins. Storage is 80x60 cells, each replicated as an 8x8 pixel block, and is held in one single-port RAM shared between scan-out reads and CPU writes.

---
 rtl/vga_framebuffer.sv | 154 +++++++++++++++
 tb/tb_vga_framebuffer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_framebuffer.sv
// rtl/vga_framebuffer.sv - 12-bit cell framebuffer with VGA scan-out and CPU write port
//
// Purpose: holds FB_W x FB_H colour cells in one single-port RAM; each cell is
// shown as an 8x8 pixel block. The scan engine owns the RAM on every pixel
// enable cycle (read slot); CPU writes take the remaining cycles.
//
// Ports:
//   i_clk      clock
//   i_rst      asynchronous active-low reset
//   wr_valid   CPU write request
//   wr_addr    linear cell index row*FB_W + col (out-of-range writes are dropped)
//   wr_data    colour {r[3:0], g[3:0], b[3:0]}
//   wr_ready   write accepted when wr_valid && wr_ready
//   hsync      horizontal sync, active low
//   vsync      vertical sync, active low
//   red/green/blue  pixel colour, zero outside the visible area
//   o_vblank   high while the line counter is in vertical blanking
//   o_frame    one-clock pulse after the last pixel slot of a frame
module vga_framebuffer #(
    parameter int CLK_DIV = 4,
    parameter int FB_W    = 80,
    parameter int FB_H    = 60,
    parameter int H_VIS   = 640,
    parameter int H_FP    = 16,
    parameter int H_SYNC  = 96,
    parameter int H_BP    = 48,
    parameter int V_VIS   = 480,
    parameter int V_FP    = 10,
    parameter int V_SYNC  = 2,
    parameter int V_BP    = 33
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        wr_valid,
    input  logic [12:0] wr_addr,
    input  logic [11:0] wr_data,
    output logic        wr_ready,
    output logic        hsync,
    output logic        vsync,
    output logic [3:0]  red,
    output logic [3:0]  green,
    output logic [3:0]  blue,
    output logic        o_vblank,
    output logic        o_frame
);

    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int CELLS = FB_W * FB_H;
    localparam int AW    = (CELLS > 1) ? $clog2(CELLS) : 1;
    localparam int DW    = $clog2(CLK_DIV);

    localparam logic [12:0] FB_W13  = 13'(FB_W);
    localparam logic [12:0] CELLS13 = 13'(CELLS);

    logic [DW-1:0] div_q, div_d;
    logic [9:0]    h_q, h_d;
    logic [9:0]    v_q, v_d;
    logic          rel_q;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          vis_q, vis_d;
    logic          frame_q, frame_d;
    logic [11:0]   rd_q;

    logic          pe;
    logic          visible;
    logic          rd_ok;
    logic          wr_en;
    logic [12:0]   rd_addr;

    logic [11:0]   mem [CELLS];

    always_comb begin
        pe      = (div_q == '0);
        div_d   = (div_q == DW'(CLK_DIV - 1)) ? '0 : div_q + 1'b1;

        // Counters step once per pixel, at the end of the read slot.
        h_d = h_q;
        v_d = v_q;
        if (pe) begin
            if (h_q == 10'(H_TOT - 1)) begin
                h_d = '0;
                v_d = (v_q == 10'(V_TOT - 1)) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
        end

        visible = (h_q < 10'(H_VIS)) && (v_q < 10'(V_VIS));
        rd_addr = 13'(v_q >> 3) * FB_W13 + 13'(h_q >> 3);
        rd_ok   = visible && (rd_addr < CELLS13);

        // The RAM port belongs to the scan-out in pe cycles, so the CPU is
        // simply held off then; rel_q keeps the port closed until the first
        // clock after reset release has passed.
        wr_ready = !pe && rel_q;
        wr_en    = wr_valid && wr_ready && (wr_addr < CELLS13);

        // Output stage captures the slot's decode together with the RAM read.
        vis_d   = vis_q;
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        if (pe) begin
            vis_d   = rd_ok;
            hsync_d = !((h_q >= 10'(H_VIS + H_FP)) && (h_q < 10'(H_VIS + H_FP + H_SYNC)));
            vsync_d = !((v_q >= 10'(V_VIS + V_FP)) && (v_q < 10'(V_VIS + V_FP + V_SYNC)));
        end
        frame_d = pe && (h_q == 10'(H_TOT - 1)) && (v_q == 10'(V_TOT - 1));
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            div_q   <= '0;
            h_q     <= '0;
            v_q     <= '0;
            rel_q   <= 1'b0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            vis_q   <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            div_q   <= div_d;
            h_q     <= h_d;
            v_q     <= v_d;
            rel_q   <= 1'b1;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            vis_q   <= vis_d;
            frame_q <= frame_d;
        end
    end

    // Single-port RAM: one access per clock, read in pe cycles, write otherwise.
    // Contents survive reset; rd_q is masked by vis_q so it needs no reset.
    always_ff @(posedge i_clk) begin
        if (pe) begin
            if (rd_ok) begin
                rd_q <= mem[rd_addr[AW-1:0]];
            end
        end else if (wr_en) begin
            mem[wr_addr[AW-1:0]] <= wr_data;
        end
    end

    assign hsync    = hsync_q;
    assign vsync    = vsync_q;
    assign red      = vis_q ? rd_q[11:8] : 4'h0;
    assign green    = vis_q ? rd_q[7:4]  : 4'h0;
    assign blue     = vis_q ? rd_q[3:0]  : 4'h0;
    assign o_vblank = (v_q >= 10'(V_VIS));
    assign o_frame  = frame_q;

endmodule

// File: tb/tb_vga_framebuffer.sv
// tb/tb_vga_framebuffer.sv - self-checking bench for vga_framebuffer on a reduced raster
module tb_vga_framebuffer;

    localparam int CD = 4;
    localparam int FW = 4;
    localparam int FH = 3;
    localparam int HV = 32, HF = 4, HS = 8, HB = 4;
    localparam int VV = 24, VF = 2, VS = 2, VB = 4;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FRM_PIX  = HT * VT;
    localparam int LINE_CLK = HT * CD;
    localparam int FRM_CLK  = FRM_PIX * CD;
    localparam int CELLS    = FW * FH;

    logic        i_clk;
    logic        i_rst;
    logic        wr_valid;
    logic [12:0] wr_addr;
    logic [11:0] wr_data;
    logic        wr_ready;
    logic        hsync;
    logic        vsync;
    logic [3:0]  red;
    logic [3:0]  green;
    logic [3:0]  blue;
    logic        o_vblank;
    logic        o_frame;

    vga_framebuffer #(
        .CLK_DIV(CD), .FB_W(FW), .FB_H(FH),
        .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .hsync(hsync), .vsync(vsync),
        .red(red), .green(green), .blue(blue),
        .o_vblank(o_vblank), .o_frame(o_frame)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int          n_assert;
    int          n_fail;
    int          t;
    int          line_now;
    int          out_h;
    int          out_v;
    bit          out_valid;
    bit          in_rst;
    bit          prev_rdy;
    bit          acc;
    bit          rgb_on;
    logic        e_hs, e_vs, e_vb, e_fr, e_rdy;
    logic [11:0] e_rgb;
    logic [11:0] mdl_mem [];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (t=%0d)", tag, obs, exp, t);
        end
    endtask

    task automatic check_all();
        check("hsync", hsync, e_hs);
        check("vsync", vsync, e_vs);
        check("o_vblank", o_vblank, e_vb);
        check("o_frame", o_frame, e_fr);
        check("wr_ready", wr_ready, e_rdy);
        if (rgb_on) check("rgb", {red, green, blue}, e_rgb);
    endtask

    // Reference: cycle t after release is a pixel slot when t % CD == 0; the
    // pins during cycle t show the slot taken at t-1. Position comes from
    // plain division of the slot count by the raster totals.
    task automatic tick();
        int p, h, v, idx;
        @(negedge i_clk);
        acc = 1'b0;
        if (i_rst && wr_valid && prev_rdy) begin
            acc = 1'b1;
            idx = int'(wr_addr);
            if (idx < CELLS) mdl_mem[idx] = wr_data;
        end
        if (!i_rst) begin
            t = 0;
            in_rst = 1'b1;
            e_hs = 1'b1; e_vs = 1'b1; e_rgb = 12'h0;
            e_vb = 1'b0; e_fr = 1'b0; e_rdy = 1'b0;
            out_valid = 1'b0;
            line_now = 0;
        end else begin
            t = t + 1;
            in_rst = 1'b0;
            e_rdy = (t % CD) != 0;
            line_now = (((t + CD - 1) / CD) / HT) % VT;
            e_vb = line_now >= VV;
            e_fr = 1'b0;
            if ((t - 1) % CD == 0) begin
                p = ((t - 1) / CD) % FRM_PIX;
                h = p % HT;
                v = p / HT;
                e_hs = !(h >= HV + HF && h < HV + HF + HS);
                e_vs = !(v >= VV + VF && v < VV + VF + VS);
                e_rgb = (h < HV && v < VV) ? mdl_mem[(v / 8) * FW + h / 8] : 12'h0;
                e_fr = (p == FRM_PIX - 1);
                out_h = h;
                out_v = v;
                out_valid = 1'b1;
            end
        end
        prev_rdy = e_rdy;
        check_all();
    endtask

    task automatic wr(input logic [12:0] a, input logic [11:0] d);
        bit got;
        got = 1'b0;
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        for (int i = 0; i < 2 * CD; i++) begin
            if (wr_ready) begin
                got = 1'b1;
                tick();
                break;
            end
            tick();
        end
        wr_valid = 1'b0;
        check("wr_accept", got, 1);
    endtask

    task automatic wait_pix(input int h, input int v);
        bit found;
        found = 1'b0;
        for (int i = 0; i < FRM_CLK + 2 * CD; i++) begin
            tick();
            if (out_valid && out_h == h && out_v == v) begin
                found = 1'b1;
                break;
            end
        end
        check("pix_reached", found, 1);
    endtask

    initial begin
        int when, hs_low, vs_low, vs_first, nz, a;
        logic [11:0] keep;
        bit found;

        n_assert = 0; n_fail = 0; t = 0; rgb_on = 1'b0; prev_rdy = 1'b0;
        out_h = 0; out_v = 0; out_valid = 1'b0; line_now = 0;
        i_rst = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        mdl_mem = new[CELLS];
        foreach (mdl_mem[k]) mdl_mem[k] = 12'h0;

        // Reset values
        repeat (10) tick();
        check("rst_hsync", hsync, 1);
        check("rst_vsync", vsync, 1);
        check("rst_rgb", {red, green, blue}, 0);
        check("rst_wr_ready", wr_ready, 0);
        check("rst_o_frame", o_frame, 0);
        check("rst_o_vblank", o_vblank, 0);
        i_rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("rdy_pattern", wr_ready, ((i + 1) % CD) != 0);
        end

        // Preload every cell with a random colour
        for (int c = 0; c < CELLS; c++) wr(13'(c), 12'($urandom_range(0, 4095)));
        repeat (2 * CD) tick();
        rgb_on = 1'b1;

        // Sync timing over a whole frame
        found = 1'b0;
        for (int i = 0; i < FRM_CLK + 8; i++) begin
            tick();
            if (o_frame) begin found = 1'b1; break; end
        end
        check("frame_seen", found, 1);
        when = -1; hs_low = 0; vs_low = 0; vs_first = -1;
        for (int i = 1; i <= FRM_CLK + 2; i++) begin
            tick();
            if (i <= LINE_CLK && !hsync) hs_low++;
            if (i <= FRM_CLK && !vsync) begin
                vs_low++;
                if (vs_first < 0) vs_first = i;
            end
            if (o_frame && when < 0) when = i;
        end
        check("frame_period", when, FRM_CLK);
        check("hsync_low_per_line", hs_low, HS * CD);
        check("vsync_low_per_frame", vs_low, VS * LINE_CLK);
        check("vsync_start", vs_first, (VV + VF) * LINE_CLK + CD);

        // Random writes, including out-of-range addresses
        for (int k = 0; k < 150; k++) begin
            repeat ($urandom_range(0, 5)) tick();
            a = ($urandom_range(0, 7) == 0) ? int'($urandom_range(CELLS, 8191))
                                             : int'($urandom_range(0, CELLS - 1));
            wr(13'(a), 12'($urandom_range(0, 4095)));
        end
        repeat (FRM_CLK) tick();

        // Single cell write and its 8x8 block
        for (int c = 0; c < CELLS; c++) wr(13'(c), 12'h000);
        wr(13'(FW + 1), 12'hF0A);
        wait_pix(7, 8);
        check("px7_8", {red, green, blue}, 12'h000);
        wait_pix(8, 8);
        check("px8_8_red", red, 4'hF);
        check("px8_8_green", green, 4'h0);
        check("px8_8_blue", blue, 4'hA);
        wait_pix(16, 8);
        check("px16_8", {red, green, blue}, 12'h000);
        wait_pix(15, 15);
        check("px15_15", {red, green, blue}, 12'hF0A);

        // Handshake across a pe cycle, second write wins
        for (int i = 0; i < 2 * CD; i++) begin
            tick();
            if (!e_rdy) break;
        end
        check("hs_pe_not_ready", wr_ready, 0);
        wr_valid = 1'b1; wr_addr = 13'(FW + 2); wr_data = 12'h123;
        tick();
        check("hs_ready_after_pe", wr_ready, 1);
        tick();
        wr_data = 12'h5C7;
        check("hs_ready_second", wr_ready, 1);
        tick();
        wr_valid = 1'b0;
        wait_pix(16, 8);
        check("hs_last_wins", {red, green, blue}, 12'h5C7);

        // Out-of-range writes leave RAM untouched
        wr(13'(FW + 1), 12'h000);
        wr(13'(FW + 2), 12'h000);
        wr(13'(CELLS), 12'hFFF);
        wr(13'd4800, 12'hFFF);
        wr(13'd8191, 12'hFFF);
        nz = 0;
        for (int i = 0; i < FRM_CLK; i++) begin
            tick();
            if ({red, green, blue} != 12'h000) nz++;
        end
        check("oor_frame_zero", nz, 0);

        // Reset in the middle of a visible line
        keep = 12'($urandom_range(1, 4095));
        wr(13'd0, keep);
        found = 1'b0;
        for (int i = 0; i < FRM_CLK + 8; i++) begin
            tick();
            if (line_now == 20) begin found = 1'b1; break; end
        end
        check("line20_reached", found, 1);
        i_rst = 1'b0;
        wr_valid = 1'b1; wr_addr = 13'd0; wr_data = ~keep;
        #1;
        check("mid_rst_hsync", hsync, 1);
        check("mid_rst_vsync", vsync, 1);
        check("mid_rst_rgb", {red, green, blue}, 0);
        check("mid_rst_wr_ready", wr_ready, 0);
        check("mid_rst_o_frame", o_frame, 0);
        check("mid_rst_o_vblank", o_vblank, 0);
        repeat (3) tick();
        wr_valid = 1'b0;
        i_rst = 1'b1;
        when = -1;
        for (int i = 1; i <= FRM_CLK + 8; i++) begin
            tick();
            if (o_frame) begin when = i; break; end
        end
        check("rst_frame_delay", when, (FRM_PIX - 1) * CD + 1);
        wait_pix(0, 0);
        check("rst_write_dropped", {red, green, blue}, keep);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
